// File: rtl/elevator_scheduler.sv
// ============================================================================
// Module  : elevator_scheduler
// Purpose : Single-car elevator controller. Latches floor calls, travels
//           toward them with a fixed per-floor travel time, opens the door
//           for a fixed dwell at each served floor, and keeps going in the
//           current direction while any request remains ahead.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module elevator_scheduler #(
  parameter int NUM_FLOORS   = 10,
  parameter int TRAVEL_TICKS = 10000000,
  parameter int DOOR_TICKS   = 20000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [3:0]            current_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [1:0]            state,
  output logic                  door_open,
  output logic                  idle
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DOOR = 2'b01,
    S_UP   = 2'b10,
    S_DOWN = 2'b11
  } state_t;

  localparam logic [31:0] TRAVEL_LAST = 32'(TRAVEL_TICKS - 1);
  localparam logic [31:0] DOOR_LAST   = 32'(DOOR_TICKS - 1);
  localparam logic [3:0]  TOP_FLOOR   = 4'(NUM_FLOORS - 1);

  state_t                  st;
  logic                    dir_up;
  logic [31:0]             travel_cnt;
  logic [31:0]             dwell_cnt;

  logic [31:0]             cf32;
  logic [NUM_FLOORS-1:0]   here_mask;
  logic [NUM_FLOORS-1:0]   above_mask;
  logic [NUM_FLOORS-1:0]   below_mask;
  logic [NUM_FLOORS-1:0]   next_mask;
  logic [3:0]              next_floor;
  logic                    at_edge;
  logic                    pend_here;
  logic                    any_above;
  logic                    any_below;
  state_t                  d_state;
  logic                    d_dir;

  assign state = st;
  assign cf32  = {28'd0, current_floor};

  // Floor masks relative to the car position (avoids narrow-index selects).
  always_comb begin
    here_mask  = '0;
    above_mask = '0;
    below_mask = '0;
    next_mask  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      here_mask[i]  = (32'(i) == cf32);
      above_mask[i] = (32'(i) > cf32);
      below_mask[i] = (32'(i) < cf32);
      if (st == S_UP) next_mask[i] = (32'(i) == cf32 + 32'd1);
      else            next_mask[i] = (32'(i) + 32'd1 == cf32);
    end
  end

  // Arrival floor for the current move and whether it is a shaft end.
  always_comb begin
    next_floor = (st == S_UP) ? current_floor + 4'd1 : current_floor - 4'd1;
    at_edge    = (st == S_UP) ? (next_floor == TOP_FLOOR) : (next_floor == 4'd0);
  end

  // Scheduling decision from the registered request mask and direction.
  always_comb begin
    pend_here = |(pending & here_mask);
    any_above = |(pending & above_mask);
    any_below = |(pending & below_mask);
    d_state   = S_IDLE;
    d_dir     = dir_up;
    if (pend_here) begin
      d_state = S_DOOR;
    end else if (any_above && (dir_up || !any_below)) begin
      d_state = S_UP;
      d_dir   = 1'b1;
    end else if (any_below) begin
      d_state = S_DOWN;
      d_dir   = 1'b0;
    end
  end

  // Controller state, request latching, counters and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= S_IDLE;
      current_floor <= '0;
      pending       <= '0;
      dir_up        <= 1'b1;
      travel_cnt    <= '0;
      dwell_cnt     <= '0;
      door_open     <= 1'b0;
      idle          <= 1'b1;
    end else begin
      pending <= pending | call_req;
      case (st)
        S_IDLE: begin
          st        <= d_state;
          dir_up    <= d_dir;
          door_open <= (d_state == S_DOOR);
          idle      <= (d_state == S_IDLE);
          if (d_state == S_DOOR) pending <= (pending | call_req) & ~here_mask;
        end
        S_DOOR: begin
          // A call at the open floor only extends the dwell; it never latches.
          pending <= (pending | call_req) & ~here_mask;
          if (|(call_req & here_mask)) begin
            dwell_cnt <= '0;
          end else if (dwell_cnt == DOOR_LAST) begin
            dwell_cnt <= '0;
            st        <= d_state;
            dir_up    <= d_dir;
            door_open <= (d_state == S_DOOR);
            idle      <= (d_state == S_IDLE);
          end else begin
            dwell_cnt <= dwell_cnt + 32'd1;
          end
        end
        default: begin
          if (travel_cnt == TRAVEL_LAST) begin
            travel_cnt    <= '0;
            current_floor <= next_floor;
            if (|(pending & next_mask)) begin
              st        <= S_DOOR;
              door_open <= 1'b1;
              idle      <= 1'b0;
              pending   <= (pending | call_req) & ~next_mask;
            end else if (at_edge) begin
              // Defensive stop at a shaft end with nothing to serve there.
              st        <= S_IDLE;
              door_open <= 1'b0;
              idle      <= 1'b1;
            end
          end else begin
            travel_cnt <= travel_cnt + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
// ============================================================================
// Module  : tb_elevator_scheduler
// Purpose : Directed stimulus for elevator_scheduler (4 floors, travel 4,
//           dwell 3) with a stop scoreboard: expected stops are queued when
//           calls are issued and popped by a monitor each time the door closes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_elevator_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] call_req = 4'b0000;
  logic [3:0] current_floor;
  logic [3:0] pending;
  logic [1:0] state;
  logic       door_open;
  logic       idle;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int floor;
    int dur;
  } stop_t;
  stop_t exp_q[$];

  elevator_scheduler #(
    .NUM_FLOORS  (4),
    .TRAVEL_TICKS(4),
    .DOOR_TICKS  (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .call_req     (call_req),
    .current_floor(current_floor),
    .pending      (pending),
    .state        (state),
    .door_open    (door_open),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_stop(input int f, input int d);
    stop_t s;
    s.floor = f;
    s.dur   = d;
    exp_q.push_back(s);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_floor"}, 32'(current_floor), 32'd0);
    chk({tag, "_pending"}, 32'(pending), 32'd0);
    chk({tag, "_door"}, 32'(door_open), 32'd0);
    chk({tag, "_idle"}, 32'(idle), 32'd1);
  endtask

  // Monitor: flag invariants every cycle and score each completed stop.
  initial begin
    stop_t e;
    int    run_len;
    int    run_floor;
    logic  prev_door;
    run_len   = 0;
    run_floor = 0;
    prev_door = 1'b0;
    forever begin
      @(negedge clk);
      chk("invariant", {29'd0, door_open == (state == 2'b01), idle == (state == 2'b00),
                        current_floor < 4'd4}, 32'd7);
      if (door_open) begin
        if (!prev_door) begin
          run_len   = 1;
          run_floor = int'(current_floor);
        end else begin
          run_len++;
        end
      end else if (prev_door) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_stop: floor %0d dwell %0d, none queued", run_floor, run_len);
        end else begin
          e = exp_q.pop_front();
          chk("stop_floor", 32'(run_floor), 32'(e.floor));
          chk("stop_dwell", 32'(run_len), 32'(e.dur));
        end
      end
      prev_door = door_open;
    end
  end

  // Directed stimulus.
  initial begin
    logic [3:0] served;
    logic [3:0] cur_bit;
    int         hold;

    // Reset values while reset is held.
    #12;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step(1);

    // Call at the current floor: one cycle to latch, then a 3-cycle dwell.
    call_req = 4'b0001;
    expect_stop(0, 3);
    step(1);
    call_req = 4'b0000;
    chk("s1_pending_latched", 32'(pending), 32'h1);
    chk("s1_state_idle", 32'(state), 32'd0);
    step(1);
    chk("s1_state_door", 32'(state), 32'd1);
    chk("s1_pending_clear", 32'(pending), 32'h0);
    step(3);
    chk("s1_idle_after", 32'(idle), 32'd1);

    // Floor 0 -> 3, stepping one floor every 4 cycles.
    call_req = 4'b1000;
    expect_stop(3, 3);
    step(1);
    call_req = 4'b0000;
    chk("s2_pending", 32'(pending), 32'h8);
    step(1);
    chk("s2_move_up", 32'(state), 32'd2);
    step(4);
    chk("s2_floor1", 32'(current_floor), 32'd1);
    step(4);
    chk("s2_floor2", 32'(current_floor), 32'd2);
    step(4);
    chk("s2_floor3", 32'(current_floor), 32'd3);
    chk("s2_door", 32'(state), 32'd1);
    step(3);
    chk("s2_idle", 32'(idle), 32'd1);

    // Return to floor 0.
    call_req = 4'b0001;
    expect_stop(0, 3);
    step(1);
    call_req = 4'b0000;
    step(20);
    chk("s3_home_floor", 32'(current_floor), 32'd0);

    // Moving up at floor 1 toward 3, new calls for 0 and 2: visit 2, 3, 0.
    call_req = 4'b1000;
    step(1);
    call_req = 4'b0000;
    step(5);
    chk("s3_at_floor1", 32'(current_floor), 32'd1);
    chk("s3_moving_up", 32'(state), 32'd2);
    call_req = 4'b0101;
    expect_stop(2, 3);
    expect_stop(3, 3);
    expect_stop(0, 3);
    step(1);
    call_req = 4'b0000;
    chk("s3_pending", 32'(pending), 32'hD);
    step(3);
    chk("s3_stop2", 32'(current_floor), 32'd2);
    step(3);
    chk("s3_keep_up", 32'(state), 32'd2);
    step(4);
    chk("s3_stop3", 32'(current_floor), 32'd3);
    step(3);
    chk("s3_reverse", 32'(state), 32'd3);
    step(12);
    chk("s3_stop0", 32'(current_floor), 32'd0);
    step(3);
    chk("s3_idle", 32'(idle), 32'd1);
    chk("s3_pending_empty", 32'(pending), 32'h0);

    // Door held by a call at the open floor for 5 cycles: dwell 5+3.
    call_req = 4'b0100;
    expect_stop(2, 8);
    step(1);
    call_req = 4'b0000;
    step(9);
    chk("s4_floor2", 32'(current_floor), 32'd2);
    chk("s4_door", 32'(door_open), 32'd1);
    call_req = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("s4_held_not_pending", 32'(pending), 32'h0);
    end
    call_req = 4'b0000;
    step(2);
    chk("s4_door_still", 32'(door_open), 32'd1);
    step(1);
    chk("s4_door_closed", 32'(door_open), 32'd0);

    // Go to floor 3, then reset asynchronously while moving down with 0101.
    call_req = 4'b1000;
    expect_stop(3, 3);
    step(1);
    call_req = 4'b0000;
    step(10);
    chk("s5_floor3", 32'(current_floor), 32'd3);
    call_req = 4'b0101;
    step(1);
    call_req = 4'b0000;
    chk("s5_pending", 32'(pending), 32'h5);
    step(1);
    chk("s5_move_down", 32'(state), 32'd3);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("s5_async");
    #3;
    rst_n = 1'b1;
    step(6);
    chk_reset_outputs("s5_after");

    // All calls held; each one dropped two cycles into its own door opening.
    expect_stop(0, 4);
    expect_stop(1, 4);
    expect_stop(2, 4);
    expect_stop(3, 4);
    served   = 4'b0000;
    hold     = 0;
    call_req = 4'b1111;
    for (int c = 0; c < 60; c++) begin
      step(1);
      cur_bit = 4'b0001 << current_floor;
      if (door_open && ((call_req & cur_bit) != 4'b0000)) begin
        hold++;
        if (hold >= 2) begin
          served = served | cur_bit;
          hold   = 0;
        end
      end
      call_req = ~served;
    end
    call_req = 4'b0000;
    chk("s6_final_floor", 32'(current_floor), 32'd3);
    chk("s6_idle", 32'(idle), 32'd1);
    chk("s6_pending_empty", 32'(pending), 32'h0);

    step(2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_FLOORS, default 10, number of served floors, legal range 2..16.
REQ-002 The block SHALL have parameter TRAVEL_TICKS, default 10000000, clock cycles spent travelling between adjacent floors, legal minimum 1.
REQ-003 The block SHALL have parameter DOOR_TICKS, default 20000000, clock cycles the door stays open per stop, legal minimum 1.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-006 The block SHALL have port call_req, input, NUM_FLOORS bits, one bit per floor, high for one or more cycles to request a stop.
REQ-007 The block SHALL have port current_floor, output, 4 bits, registered floor index, 0..NUM_FLOORS-1.
REQ-008 The block SHALL have port pending, output, NUM_FLOORS bits, registered outstanding-request mask.
REQ-009 The block SHALL have port state, output, 2 bits, encoding IDLE=00, DOOR_OPEN=01, MOVE_UP=10, MOVE_DOWN=11.
REQ-010 The block SHALL have port door_open, output, 1 bit, high exactly when state is DOOR_OPEN.
REQ-011 The block SHALL have port idle, output, 1 bit, high exactly when state is IDLE.

Function
REQ-012 Each cycle, pending SHALL be updated to pending OR call_req, except for any bit cleared by REQ-017/REQ-018, where the clear wins.
REQ-013 The block SHALL keep an internal direction flag dir_up. Decision rule D: if pending[current_floor] then DOOR_OPEN; else if any pending above and (dir_up or none pending below) then MOVE_UP with dir_up=1; else if any pending below then MOVE_DOWN with dir_up=0; else IDLE.
REQ-014 In IDLE, the next state SHALL be given by D evaluated on registered pending: a call registered at edge N yields the new state at edge N+1.
REQ-015 In MOVE_UP/MOVE_DOWN, a travel counter SHALL count 0..TRAVEL_TICKS-1. At terminal count, current_floor SHALL increment or decrement by 1 and the counter SHALL clear. The next state SHALL be DOOR_OPEN if the new floor is pending; otherwise the state SHALL continue in the same direction.
REQ-016 current_floor SHALL never leave 0..NUM_FLOORS-1. Motion is only started toward a pending floor, and a pending bit is cleared only at its floor.
REQ-017 On entry to DOOR_OPEN, pending[current_floor] SHALL be cleared in the same edge, and a dwell counter SHALL start at 0.
REQ-018 In DOOR_OPEN, call_req[current_floor] high SHALL restart the dwell counter and SHALL NOT set pending[current_floor].
REQ-019 When the dwell counter reaches DOOR_TICKS-1, the next state SHALL be given by D; at that point pending[current_floor] is 0, so the block leaves DOOR_OPEN.
REQ-020 Calls arriving for other floors during motion or dwell SHALL be latched and served per D; the block SHALL never reverse direction while requests remain ahead.
REQ-021 Counters SHALL be wide enough for the parameter values (at least 32 bits) and SHALL hold 0 when not in their state.

Reset
REQ-022 When rst_n is low, the block SHALL immediately force: state=IDLE, current_floor=0, pending=0, dir_up=1, both counters=0, door_open=0, idle=1.
REQ-023 Reset asserted mid-travel or mid-dwell SHALL discard all requests. After release, the block SHALL react only to new calls.

Verification (NUM_FLOORS=4, TRAVEL_TICKS=4, DOOR_TICKS=3)
REQ-024 Reset, call_req=0001 for 1 cycle -> pending=0001, then state DOOR_OPEN on the next edge, pending=0000, door_open high for 3 cycles, then IDLE.
REQ-025 From floor 0, pulse call_req=1000 -> MOVE_UP; current_floor steps 1,2,3 every 4 cycles; DOOR_OPEN at 3 for 3 cycles; then IDLE.
REQ-026 At floor 1 moving up toward 3, pulse calls for floors 0 and 2 -> stops at 2, then 3, then reverses to 0. Visit order: 2,3,0.
REQ-027 In DOOR_OPEN at floor 2, hold call_req[2] for 5 cycles -> door_open remains high for 5+3 cycles; pending[2] stays 0.
REQ-028 Assert rst_n low during MOVE_DOWN with pending=0101 -> outputs match REQ-022 asynchronously; after release the block stays idle with no call.
REQ-029 call_req=1111 held every cycle from floor 0 -> all floors served in order 0,1,2,3. At each stop the door opens and then closes; door_open falls within 3 cycles after the last call_req for that floor drops, per REQ-018. current_floor never exceeds 3.
